// File: rtl/pin_checker.sv
// pin_checker: assembles keypad digits into a PIN, checks it on ENTER and enforces lockout.
// Define PIN_ECHO_EN to build the masked display echo; otherwise the echo outputs are tied to 0.
module pin_checker #(
  parameter int                   PIN_LEN      = 4,
  parameter logic [4*PIN_LEN-1:0] PIN_CODE     = 16'h1234,
  parameter int                   MAX_TRIES    = 3,
  parameter int                   GRANT_CYCLES = 50_000_000,
  parameter int                   LOCK_CYCLES  = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  input  logic [6:0] i_key_ascii,
  output logic       o_granted,
  output logic       o_denied,
  output logic       o_locked,
  output logic [2:0] o_digit_count,
  output logic [3:0] o_fail_count,
  output logic       o_echo_valid,
  output logic [6:0] o_echo_ascii
);

  localparam int          BUF_W      = 4 * PIN_LEN;
  localparam logic [2:0]  LEN        = 3'(PIN_LEN);
  localparam logic [3:0]  TRIES      = 4'(MAX_TRIES);
  localparam logic [31:0] GRANT_LOAD = 32'(GRANT_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_DENY,
    S_GRANT,
    S_LOCKED
  } state_t;

  state_t           r_state;
  logic             r_key_valid_d;
  logic [BUF_W-1:0] r_pin_buf;
  logic [2:0]       r_digit_count;
  logic [3:0]       r_fail_count;
  logic [31:0]      r_timer;
  logic             r_granted;
  logic             r_denied;
  logic             r_locked;

  logic             w_event;
  logic             w_is_digit;
  logic             w_is_del;
  logic             w_is_enter;
  logic             w_in_entry;
  logic             w_accept_digit;
  logic             w_accept_del;
  logic             w_enter;
  logic             w_match;
  logic [3:0]       w_fail_next;
  logic [BUF_W-1:0] w_digit_ext;

  // Only a 0->1 transition of the strobe is a key event; keys outside ENTRY are dropped.
  assign w_event        = i_key_valid & ~r_key_valid_d;
  assign w_is_digit     = (i_key_ascii >= 7'h30) && (i_key_ascii <= 7'h39);
  assign w_is_del       = (i_key_ascii == 7'h7F);
  assign w_is_enter     = (i_key_ascii == 7'h0D);
  assign w_in_entry     = (r_state == S_ENTRY);
  assign w_accept_digit = w_event & w_in_entry & w_is_digit & (r_digit_count < LEN);
  assign w_accept_del   = w_event & w_in_entry & w_is_del & (r_digit_count != 3'd0);
  assign w_enter        = w_event & w_in_entry & w_is_enter;
  assign w_digit_ext    = BUF_W'(i_key_ascii[3:0]);
  assign w_match        = (r_digit_count == LEN) && (r_pin_buf == PIN_CODE);
  assign w_fail_next    = r_fail_count + 4'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_ENTRY;
      r_key_valid_d <= 1'b1;
      r_pin_buf     <= '0;
      r_digit_count <= 3'd0;
      r_fail_count  <= 4'd0;
      r_timer       <= 32'd0;
      r_granted     <= 1'b0;
      r_denied      <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_key_valid_d <= i_key_valid;
      r_denied      <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (w_accept_digit) begin
            r_pin_buf     <= (r_pin_buf << 4) | w_digit_ext;
            r_digit_count <= r_digit_count + 3'd1;
          end else if (w_accept_del) begin
            r_pin_buf     <= r_pin_buf >> 4;
            r_digit_count <= r_digit_count - 3'd1;
          end else if (w_enter) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            r_fail_count <= 4'd0;
            r_granted    <= 1'b1;
            r_timer      <= GRANT_LOAD;
            r_state      <= S_GRANT;
          end else begin
            r_fail_count <= w_fail_next;
            r_denied     <= 1'b1;
            if (w_fail_next == TRIES) begin
              r_locked      <= 1'b1;
              r_timer       <= LOCK_LOAD;
              r_pin_buf     <= '0;
              r_digit_count <= 3'd0;
              r_state       <= S_LOCKED;
            end else begin
              r_state <= S_DENY;
            end
          end
        end
        S_DENY: begin
          r_pin_buf     <= '0;
          r_digit_count <= 3'd0;
          r_state       <= S_ENTRY;
        end
        // Timer was loaded with N-1, so leaving on the zero read gives exactly N cycles high.
        S_GRANT: begin
          if (r_timer == 32'd0) begin
            r_granted     <= 1'b0;
            r_pin_buf     <= '0;
            r_digit_count <= 3'd0;
            r_state       <= S_ENTRY;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_LOCKED: begin
          if (r_timer == 32'd0) begin
            r_locked     <= 1'b0;
            r_fail_count <= 4'd0;
            r_state      <= S_ENTRY;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign o_granted     = r_granted;
  assign o_denied      = r_denied;
  assign o_locked      = r_locked;
  assign o_digit_count = r_digit_count;
  assign o_fail_count  = r_fail_count;

`ifdef PIN_ECHO_EN
  logic       r_echo_valid;
  logic [6:0] r_echo_ascii;

  // Digits are masked as '*'; deletes echo a backspace.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_echo_valid <= 1'b0;
      r_echo_ascii <= 7'h00;
    end else begin
      r_echo_valid <= w_accept_digit | w_accept_del;
      if (w_accept_digit) begin
        r_echo_ascii <= 7'h2A;
      end else if (w_accept_del) begin
        r_echo_ascii <= 7'h08;
      end
    end
  end

  assign o_echo_valid = r_echo_valid;
  assign o_echo_ascii = r_echo_ascii;
`else
  assign o_echo_valid = 1'b0;
  assign o_echo_ascii = 7'h00;
`endif

endmodule

// File: doc/pin_checker.md
# pin_checker

Consumes decoded ASCII key events from the matrix-keypad decoder and assembles them into a PIN of `PIN_LEN` digits. On ENTER it compares the PIN against a parameterised code and reports grant or deny. It enforces a lockout after `MAX_TRIES` consecutive failures. It sits directly downstream of the keypad decoder, in the anti-impersonation access path, and drives the unlock/alarm logic and an optional display echo.

## Interface

Parameters:

- `PIN_LEN`, 4 — digits per PIN, legal range 1..7.
- `PIN_CODE`, 16'h1234 — expected PIN, BCD, width 4*PIN_LEN, most-significant nibble is the first digit typed.
- `MAX_TRIES`, 3 — consecutive failures that trigger lockout, legal range 1..15.
- `GRANT_CYCLES`, 50_000_000 — clock cycles `granted` is held high.
- `LOCK_CYCLES`, 50_000_000 — clock cycles lockout lasts.

Ports:

- `clk` in 1 — single clock, all logic on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `key_valid` in 1 — key-done strobe from the decoder; an event is its rising edge.
- `key_ascii` in 7 — key code, valid when `key_valid` is high.
- `granted` out 1 — level, high for GRANT_CYCLES after a correct PIN.
- `denied` out 1 — one-cycle pulse per failed attempt.
- `locked` out 1 — level, high during lockout.
- `digit_count` out 3 — number of digits currently buffered.
- `fail_count` out 4 — consecutive failures so far.
- `echo_valid` out 1 — one-cycle pulse per accepted digit or delete.
- `echo_ascii` out 7 — echo character, valid with `echo_valid`.

## Operation

Key decode:

- 0x30..0x39 → digit 0..9.
- 0x7F → DELETE.
- 0x0D → ENTER.
- Any other code (including 0x00) is ignored.

Event detection:

- `key_valid_d` is a register. An event occurs on the edge where `key_valid`=1 and `key_valid_d`=0.
- `key_valid_d` resets to 1, so a key held across reset is not accepted.
- Only one event per edge is possible. Events arriving outside ENTRY are discarded, not queued.

States:

- ENTRY
  - Digit with `digit_count` < PIN_LEN: shift the BCD digit into the buffer and increment the count.
  - Digit with `digit_count` == PIN_LEN: ignored, no echo.
  - DELETE with count > 0: drop the last digit and decrement the count.
  - DELETE with count == 0: ignored.
  - ENTER: go to CHECK.
- CHECK (1 cycle)
  - Match requires `digit_count` == PIN_LEN and buffer == PIN_CODE.
  - Match: clear `fail_count`, go to GRANT.
  - Otherwise increment `fail_count`. Go to LOCKED if the new value equals MAX_TRIES, else go to DENY.
  - A short entry always fails.
- DENY (1 cycle): `denied`=1, clear buffer and count, go to ENTRY.
- GRANT: `granted`=1 and the timer counts GRANT_CYCLES. Then clear buffer and count, drop `granted`, go to ENTRY.
- LOCKED
  - On entry: `denied` pulses for 1 cycle, `locked`=1, buffer and count cleared.
  - After LOCK_CYCLES: clear `fail_count`, drop `locked`, go to ENTRY.
- The timer is a 32-bit down-counter shared by GRANT and LOCKED. It is loaded with N-1 when the state is entered, and the state exits on the cycle the counter reads 0.

## Timing

- Reset values: `granted`, `denied`, `locked`, `echo_valid` = 0; `echo_ascii` = 0; `digit_count` = 0; `fail_count` = 0. State = ENTRY, buffer = 0.
- Reset mid-GRANT or mid-LOCKED aborts immediately to the reset state.
- A digit or DELETE event sampled at edge N updates `digit_count`, and `echo_valid` is visible after edge N for exactly 1 cycle.
- An ENTER event sampled at edge N moves the state to CHECK after edge N. After edge N+1 one of the following holds for the cycle starting there:
  - `granted`=1, or
  - `denied`=1 for that cycle only, or
  - `denied`=1 for that cycle plus `locked`=1.
- `granted` stays high for exactly GRANT_CYCLES cycles, and `locked` stays high for exactly LOCK_CYCLES cycles.
- A key held down generates one event only. A new event requires `key_valid` to return to 0 for at least 1 cycle.

## Configuration

- `PIN_ECHO_EN` defined:
  - On an accepted digit, `echo_ascii` = 0x2A ('*', masked).
  - On an accepted DELETE, `echo_ascii` = 0x08 (backspace).
  - In both cases `echo_valid` pulses for 1 cycle.
- `PIN_ECHO_EN` undefined: `echo_valid` and `echo_ascii` are tied to 0 and the echo logic is not synthesised. All other behaviour is identical.

## Test plan

Benches override GRANT_CYCLES=8 and LOCK_CYCLES=16; other parameters are default.

- Keys 1,2,3,4, ENTER → `digit_count` steps 1..4. `granted` rises 2 edges after the ENTER edge and holds 8 cycles. `fail_count` stays 0.
- Keys 1,2,5, DELETE, 3,4, ENTER → `digit_count` sequence 1,2,3,2,3,4, then `granted`. With PIN_ECHO_EN, the echo sequence is 2A,2A,2A,08,2A,2A.
- Keys 9,9,9,9, ENTER, three times → `denied` pulses each time and `fail_count` reads 1,2,3. On the third attempt `locked` goes high for 16 cycles, then `fail_count` returns to 0. Keys pressed during lock do not change `digit_count`.
- Keys 1,2, ENTER → `denied` pulse, `fail_count`=1. Keys 1,2,3,4,5 → `digit_count` saturates at 4 and the fifth digit produces no echo.
- `key_valid` held high for 20 cycles with 0x31 → exactly one digit is accepted. `key_valid` held high through reset deassertion → no digit is accepted.
- `rst` asserted during GRANT at cycle 3 → all outputs 0 on the next cycle. Keys 1,2,3,4, ENTER afterwards grants normally.
